// File: rtl/mm_stage.sv
// mm_stage: memory-access stage of the 5-stage RISC-V core.
// Takes the registered EX results and, for loads/stores, moves data one byte
// per granted cycle over the shared byte-wide memory port. It holds EX/MEM with
// stl_req while busy and presents registered writeback results to WB.
// Optional feature macro: MM_MISALIGN_TRAP_EN (misaligned H/W accesses skip
// memory and raise a one-cycle mm_trap instead of going byte-serial).
module mm_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mm_wa,
  input  logic              mm_we,
  input  logic [31:0]       mm_wn,
  input  logic [4:0]        mm_mem_e,
  input  logic [31:0]       mm_mem_n,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              mem_req,
  output logic              stl_req,
  output logic [4:0]        wb_wa,
  output logic              wb_we,
  output logic [31:0]       wb_wn,
  output logic              mm_trap
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        ctl_q;
  logic [2:0]        cnt;
  logic [2:0]        cnt_m1;
  logic              pend;
  logic [31:0]       rdata;
  logic [31:0]       ld_val;
  logic [2:0]        last_idx;
  logic              is_acc;
  logic              trap_in;
  logic              trap_done;
  logic              ctl_store;
  logic              ctl_uns;
  logic [1:0]        ctl_size;

  assign is_acc    = mm_mem_e[4];
  assign ctl_store = ctl_q[3];
  assign ctl_uns   = ctl_q[2];
  assign ctl_size  = ctl_q[1:0];
  assign cnt_m1    = cnt - 3'd1;

`ifdef MM_MISALIGN_TRAP_EN
  logic trap_q;

  assign trap_in = is_acc &&
                   (((mm_mem_e[1:0] == 2'b01) && mm_wn[0]) ||
                    (mm_mem_e[1] && (mm_wn[1:0] != 2'b00)));

  // Remember whether the access accepted in IDLE was a misaligned trap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      trap_q <= 1'b0;
    else if ((state == S_IDLE) && is_acc)
      trap_q <= trap_in;
  end

  assign trap_done = (state == S_DONE) && trap_q;
`else
  assign trap_in   = 1'b0;
  assign trap_done = 1'b0;
`endif

  assign mm_trap = trap_done;

  // Index of the final byte of the latched access (reserved size acts as word)
  always_comb begin
    last_idx = 3'd3;
    case (ctl_size)
      2'b00:   last_idx = 3'd0;
      2'b01:   last_idx = 3'd1;
      default: last_idx = 3'd3;
    endcase
  end

  // Sign- or zero-extend the assembled load data according to size
  always_comb begin
    ld_val = rdata;
    case (ctl_size)
      2'b00:   ld_val = ctl_uns ? {24'h0, rdata[7:0]}  : {{24{rdata[7]}},  rdata[7:0]};
      2'b01:   ld_val = ctl_uns ? {16'h0, rdata[15:0]} : {{16{rdata[15]}}, rdata[15:0]};
      default: ld_val = rdata;
    endcase
  end

  // Next-state logic and memory-port / stall outputs
  always_comb begin
    state_nxt = state;
    stl_req   = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_a     = '0;
    mem_dout  = 8'h00;
    case (state)
      S_IDLE: begin
        if (is_acc) begin
          stl_req   = 1'b1;
          state_nxt = trap_in ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        stl_req  = 1'b1;
        mem_req  = 1'b1;
        mem_a    = addr_q + ADDR_W'(cnt);
        mem_wr   = ctl_store;
        mem_dout = data_q[{cnt[1:0], 3'b000} +: 8];
        if (mem_gnt && (cnt == last_idx))
          state_nxt = ctl_store ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stl_req   = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Access context, byte counter and load-byte assembly; pend marks that the
  // previous cycle issued a granted read whose byte is on mem_din now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= 32'h0;
      ctl_q  <= 4'h0;
      cnt    <= 3'd0;
      pend   <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_acc) begin
            addr_q <= mm_wn[ADDR_W-1:0];
            data_q <= mm_mem_n;
            ctl_q  <= mm_mem_e[3:0];
            cnt    <= 3'd0;
            pend   <= 1'b0;
            rdata  <= 32'h0;
          end
        end
        S_ACC: begin
          pend <= mem_gnt && !ctl_store;
          if (mem_gnt)
            cnt <= cnt + 3'd1;
          if (pend)
            rdata[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
        end
        S_WAIT: begin
          pend <= 1'b0;
          if (pend)
            rdata[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
        end
        default: ;
      endcase
    end
  end

  // MEM/WB register: passthrough in IDLE, bubble while busy, result in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wa <= 5'd0;
      wb_we <= 1'b0;
      wb_wn <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!is_acc) begin
            wb_wa <= mm_wa;
            wb_we <= mm_we;
            wb_wn <= mm_wn;
          end else begin
            wb_we <= 1'b0;
          end
        end
        S_DONE: begin
          wb_wa <= mm_wa;
          wb_we <= mm_we && !trap_done;
          wb_wn <= (!ctl_store && !trap_done) ? ld_val : mm_wn;
        end
        default: wb_we <= 1'b0;
      endcase
    end
  end

endmodule
